ads_frame_reader: RTL and testbench

Read-side client of the ads_async_fifo audio sample FIFO. Waits until a complete G729 analysis frame (FRAME_LEN samples) is buffered, then drains exactly FRAME_LEN samples using the FIFO's read-enable/read-data interface. Presents the samples to the LPC/Levinson-Durbin path as a valid/ready stream tagged with index, first and last markers. Runs on the system clock domain alongside the FIFO.

---
 rtl/ads_frame_reader.sv | 176 +++++++++++++++++
 tb/tb_ads_frame_reader.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads_frame_reader.sv
// Frame-granular reader for the audio sample FIFO: waits for a full frame, drains it, and streams it out.
// Optional statistics outputs are compiled in with `define ADS_FRM_RD_STATS_EN.
module ads_frame_reader #(
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int FRAME_LEN      = 80,
  parameter int IDX_WIDTH      = 7
) (
  input  logic                      sys_clk,
  input  logic                      sys_srst,
  input  logic                      sys_ce,
  input  logic                      frm_enable,
  input  logic [RAM_ADDR_WIDTH-1:0] aff_data_count,
  input  logic                      aff_data_empty,
  input  logic [RAM_DATA_WIDTH-1:0] aff_read_data,
  output logic                      ldb_read_en,
  output logic [RAM_DATA_WIDTH-1:0] frm_sample,
  output logic                      frm_smp_valid,
  input  logic                      frm_ready,
  output logic [IDX_WIDTH-1:0]      frm_sample_idx,
  output logic                      frm_first,
  output logic                      frm_last,
  output logic                      frm_done,
  output logic                      frm_busy
`ifdef ADS_FRM_RD_STATS_EN
  ,
  output logic [15:0]               frm_count,
  output logic                      frm_underrun,
  output logic [15:0]               frm_stall_cycles
`endif
);

  // state    | meaning
  // ST_IDLE  | waiting for a full frame in the FIFO and frm_enable
  // ST_READ  | popping samples, one per cycle when the output slot is free
  // ST_DRAIN | all samples popped, waiting for the last one to be accepted
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  localparam logic [RAM_ADDR_WIDTH-1:0] FRAME_LEN_C = RAM_ADDR_WIDTH'(FRAME_LEN);
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_CNT    = RAM_ADDR_WIDTH'(FRAME_LEN - 1);

  state_t                      state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [RAM_DATA_WIDTH-1:0]   sample_q, sample_d;
  logic                        valid_q, valid_d;
  logic [IDX_WIDTH-1:0]        idx_q, idx_d;
  logic                        first_q, first_d;
  logic                        last_q, last_d;
  logic                        done_q, done_d;

  logic can_load;
  logic accept;
  logic pop;

  assign can_load = !valid_q || frm_ready;
  // sys_ce gates the accept so a frozen block never retires a sample
  assign accept   = sys_ce && valid_q && frm_ready;
  assign pop      = sys_ce && !sys_srst && (state_q == ST_READ) && !aff_data_empty && can_load;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    first_d  = first_q;
    last_d   = last_q;
    done_d   = 1'b0;

    if (sys_ce) begin
      case (state_q)
        ST_IDLE: begin
          rd_cnt_d = '0;
          if (frm_enable && (aff_data_count >= FRAME_LEN_C)) begin
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          if (pop) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST_CNT) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (pop) begin
        sample_d = aff_read_data;
        valid_d  = 1'b1;
        idx_d    = IDX_WIDTH'(rd_cnt_q);
        first_d  = (rd_cnt_q == '0);
        last_d   = (rd_cnt_q == LAST_CNT);
      end else if (accept) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_srst) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign ldb_read_en    = pop;
  assign frm_sample     = sample_q;
  assign frm_smp_valid  = valid_q;
  assign frm_sample_idx = idx_q;
  assign frm_first      = first_q;
  assign frm_last       = last_q;
  assign frm_done       = done_q && sys_ce;
  assign frm_busy       = (state_q != ST_IDLE);

`ifdef ADS_FRM_RD_STATS_EN
  logic [15:0] count_q, count_d;
  logic        underrun_q, underrun_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    count_d    = count_q;
    underrun_d = underrun_q;
    stall_d    = stall_q;
    if (done_d) begin
      count_d = count_q + 16'd1;
    end
    if (sys_ce && (state_q == ST_READ) && aff_data_empty && can_load) begin
      underrun_d = 1'b1;
    end
    // saturating, so a long-stuck consumer still reads as "very stalled"
    if (sys_ce && valid_q && !frm_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_srst) begin
      count_q    <= '0;
      underrun_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      count_q    <= count_d;
      underrun_q <= underrun_d;
      stall_q    <= stall_d;
    end
  end

  assign frm_count        = count_q;
  assign frm_underrun     = underrun_q;
  assign frm_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ads_frame_reader.sv
// Bench for ads_frame_reader: FIFO model, stream scoreboard and scenario tasks.
// Stats checks are included when ADS_FRM_RD_STATS_EN is defined.
module tb_ads_frame_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FL = 80;
  localparam int IW = 7;

  logic          sys_clk = 1'b0;
  logic          sys_srst;
  logic          sys_ce;
  logic          frm_enable;
  logic [AW-1:0] aff_data_count;
  logic          aff_data_empty;
  logic [DW-1:0] aff_read_data;
  logic          ldb_read_en;
  logic [DW-1:0] frm_sample;
  logic          frm_smp_valid;
  logic          frm_ready;
  logic [IW-1:0] frm_sample_idx;
  logic          frm_first, frm_last, frm_done, frm_busy;
`ifdef ADS_FRM_RD_STATS_EN
  logic [15:0]   frm_count, frm_stall_cycles;
  logic          frm_underrun;
`endif

  ads_frame_reader #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .FRAME_LEN(FL), .IDX_WIDTH(IW)) dut (
    .sys_clk(sys_clk), .sys_srst(sys_srst), .sys_ce(sys_ce), .frm_enable(frm_enable),
    .aff_data_count(aff_data_count), .aff_data_empty(aff_data_empty), .aff_read_data(aff_read_data),
    .ldb_read_en(ldb_read_en), .frm_sample(frm_sample), .frm_smp_valid(frm_smp_valid),
    .frm_ready(frm_ready), .frm_sample_idx(frm_sample_idx), .frm_first(frm_first),
    .frm_last(frm_last), .frm_done(frm_done), .frm_busy(frm_busy)
`ifdef ADS_FRM_RD_STATS_EN
    , .frm_count(frm_count), .frm_underrun(frm_underrun), .frm_stall_cycles(frm_stall_cycles)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model: array storage, write pointer owned by the stimulus, read pointer by the pop logic
  logic [DW-1:0] mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_floor = 0;
  int head;
  logic force_empty = 1'b0;

  assign head           = (rd_ptr > rd_floor) ? rd_ptr : rd_floor;
  assign aff_data_count = AW'(wr_ptr - head);
  assign aff_data_empty = (wr_ptr == head) || force_empty;
  assign aff_read_data  = mem[head[10:0]];

  always @(posedge sys_clk) if (ldb_read_en === 1'b1) rd_ptr <= head + 1;

  typedef struct { logic [DW-1:0] data; int idx; } pend_t;
  pend_t pend[$];
  pend_t pe;
  logic [DW-1:0] acc_log[$];
  logic [DW-1:0] exp_v[$];
  int pop_cyc[$];

  int n_tests = 0;
  int n_fail = 0;
  int n_pops, n_done, n_stall, cyc = 0, pos = 0;
  bit mon_en = 0, prev_srst = 1, prev_acc_last = 0, acc_last, exp_valid, exp_done;
  int busy_low, found;
  logic [DW-1:0] v;

  task step();
    @(negedge sys_clk); #1;
  endtask

  task push_val(input logic [DW-1:0] d);
    mem[wr_ptr[10:0]] = d;
    wr_ptr++;
    exp_v.push_back(d);
  endtask

  task do_reset();
    sys_srst = 1; frm_enable = 0; force_empty = 0; sys_ce = 1; frm_ready = 1;
    step(); step();
    rd_floor = wr_ptr;
    sys_srst = 0;
    n_pops = 0; n_done = 0; n_stall = 0;
    acc_log.delete(); pop_cyc.delete(); exp_v.delete();
  endtask

  // Stream scoreboard: every pop must reappear on the output, in order, exactly once
  task monitor_loop();
    forever begin
      @(negedge sys_clk); #3;
      if (mon_en) begin
        if (prev_srst) begin
          n_tests++;
          if ({frm_smp_valid, frm_sample, frm_sample_idx, frm_first, frm_last, frm_done, frm_busy} !== '0) begin
            n_fail++;
            $display("FAIL mon_reset_outputs cyc=%0d got valid=%b sample=%h idx=%0d busy=%b expected all zero",
                     cyc, frm_smp_valid, frm_sample, frm_sample_idx, frm_busy);
          end
        end
        exp_valid = (pend.size() != 0);
        n_tests++;
        if (frm_smp_valid !== exp_valid) begin
          n_fail++;
          $display("FAIL mon_valid cyc=%0d got %b expected %b", cyc, frm_smp_valid, exp_valid);
        end
        if (exp_valid && frm_smp_valid === 1'b1) begin
          n_tests++;
          if (frm_sample !== pend[0].data || frm_sample_idx !== IW'(pend[0].idx) ||
              frm_first !== (pend[0].idx == 0) || frm_last !== (pend[0].idx == FL - 1)) begin
            n_fail++;
            $display("FAIL mon_sample cyc=%0d got data=%h idx=%0d first=%b last=%b expected data=%h idx=%0d",
                     cyc, frm_sample, frm_sample_idx, frm_first, frm_last, pend[0].data, pend[0].idx);
          end
        end
        exp_done = prev_acc_last && sys_ce;
        n_tests++;
        if (frm_done !== exp_done) begin
          n_fail++;
          $display("FAIL mon_done cyc=%0d got %b expected %b", cyc, frm_done, exp_done);
        end
        acc_last = 0;
        if (sys_ce && !sys_srst && frm_smp_valid === 1'b1 && frm_ready && pend.size() != 0) begin
          acc_log.push_back(pend[0].data);
          acc_last = (pend[0].idx == FL - 1);
          void'(pend.pop_front());
        end
        if (ldb_read_en === 1'b1) begin
          n_tests++;
          if (!(sys_ce && !sys_srst && !aff_data_empty && (!frm_smp_valid || frm_ready) && frm_busy)) begin
            n_fail++;
            $display("FAIL mon_pop_legal cyc=%0d got pop=1 ce=%b srst=%b empty=%b valid=%b ready=%b expected no pop",
                     cyc, sys_ce, sys_srst, aff_data_empty, frm_smp_valid, frm_ready);
          end
          pe.data = aff_read_data; pe.idx = pos;
          pend.push_back(pe);
          pos = (pos + 1) % FL;
          n_pops++;
          pop_cyc.push_back(cyc);
        end
        if (frm_done === 1'b1) n_done++;
        if (sys_ce && !sys_srst && frm_smp_valid === 1'b1 && !frm_ready) n_stall++;
        if (sys_srst) begin
          pend.delete(); pos = 0; acc_last = 0;
        end
        prev_acc_last = acc_last;
        prev_srst = sys_srst;
      end
      cyc++;
    end
  endtask

  task test_reset();
    sys_srst = 1; sys_ce = 1; frm_enable = 0; frm_ready = 0;
    step(); step(); step();
    n_tests++;
    if ({frm_smp_valid, frm_sample, frm_sample_idx, frm_first, frm_last, frm_done, frm_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got valid=%b sample=%h idx=%0d busy=%b expected zeros",
               frm_smp_valid, frm_sample, frm_sample_idx, frm_busy);
    end
    n_tests++;
    if (ldb_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_pop got %b expected 0", ldb_read_en); end
`ifdef ADS_FRM_RD_STATS_EN
    n_tests++;
    if (frm_count !== 16'd0 || frm_underrun !== 1'b0 || frm_stall_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stats got %0d/%b/%0d expected 0/0/0", frm_count, frm_underrun, frm_stall_cycles);
    end
`endif
    mon_en = 1;
    do_reset();
  endtask

  task test_single_frame();
    do_reset();
    for (int i = 0; i < FL; i++) push_val(i);
    frm_enable = 1;
    for (int i = 0; i < 300 && n_done < 1; i++) step();
    step(); step();
    n_tests++;
    if (n_pops !== FL || n_done !== 1) begin
      n_fail++; $display("FAIL single_counts got pops=%0d done=%0d expected %0d/1", n_pops, n_done, FL);
    end
    n_tests++;
    if (pop_cyc.size() != FL || pop_cyc[FL-1] - pop_cyc[0] != FL - 1) begin
      n_fail++; $display("FAIL single_consecutive got %0d pops spread wrongly expected %0d consecutive", pop_cyc.size(), FL);
    end
    for (int i = 0; i < FL; i++) begin
      n_tests++;
      if (i >= acc_log.size() || acc_log[i] !== DW'(i)) begin
        n_fail++; $display("FAIL single_data[%0d] got %h expected %h", i, (i < acc_log.size()) ? acc_log[i] : 'x, i);
      end
    end
    n_tests++;
    if (aff_data_count !== '0) begin n_fail++; $display("FAIL single_fifo_left got %0d expected 0", aff_data_count); end
  endtask

  task test_threshold();
    do_reset();
    for (int i = 0; i < FL - 1; i++) push_val($urandom);
    frm_enable = 1;
    for (int i = 0; i < 6; i++) step();
    n_tests++;
    if (n_pops !== 0 || frm_busy !== 1'b0 || ldb_read_en !== 1'b0) begin
      n_fail++; $display("FAIL thresh_below got pops=%0d busy=%b expected 0/0", n_pops, frm_busy);
    end
    push_val($urandom);
    step();
    n_tests++;
    if (frm_busy !== 1'b1 || ldb_read_en !== 1'b1 || n_pops !== 0) begin
      n_fail++; $display("FAIL thresh_enter got busy=%b pop=%b pops=%0d expected 1/1/0", frm_busy, ldb_read_en, n_pops);
    end
    for (int i = 0; i < 300 && n_done < 1; i++) step();
    n_tests++;
    if (acc_log.size() != FL || acc_log != exp_v || n_done !== 1) begin
      n_fail++; $display("FAIL thresh_frame got %0d samples done=%0d expected %0d samples in order, 1 done", acc_log.size(), n_done, FL);
    end
  endtask

  task test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < FL; i++) push_val($urandom);
    frm_enable = 1;
    for (int i = 0; i < 800 && n_done < 1; i++) begin
      frm_ready = pat[i % 4];
      step();
    end
    frm_ready = 1;
    n_tests++;
    if (acc_log.size() != FL || acc_log != exp_v || n_done !== 1) begin
      n_fail++; $display("FAIL bp_frame got %0d samples done=%0d expected %0d samples in order, 1 done", acc_log.size(), n_done, FL);
    end
`ifdef ADS_FRM_RD_STATS_EN
    n_tests++;
    if (frm_stall_cycles !== 16'(n_stall)) begin
      n_fail++; $display("FAIL bp_stall_cycles got %0d expected %0d", frm_stall_cycles, n_stall);
    end
`endif
  endtask

  task test_reset_mid();
    do_reset();
    for (int i = 0; i < FL; i++) push_val(i);
    frm_enable = 1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (frm_smp_valid === 1'b1 && frm_sample_idx === IW'(39)) found = 1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rstmid_reach got no idx 39 expected it within budget"); end
    sys_srst = 1;
    step();
    sys_srst = 0;
    n_tests++;
    if ({frm_smp_valid, frm_sample, frm_sample_idx, frm_first, frm_last, frm_done, frm_busy} !== '0 || ldb_read_en !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs got valid=%b idx=%0d busy=%b expected zeros", frm_smp_valid, frm_sample_idx, frm_busy);
    end
    n_tests++;
    if (aff_data_count !== AW'(40)) begin n_fail++; $display("FAIL rstmid_fifo got %0d expected 40", aff_data_count); end
    acc_log.delete(); n_done = 0;
    for (int i = 100; i < 180; i++) push_val(i);
    for (int i = 0; i < 300 && n_done < 1; i++) step();
    n_tests++;
    if (acc_log.size() != FL || acc_log[0] !== 40 || acc_log[39] !== 79 || acc_log[40] !== 100 || acc_log[79] !== 139) begin
      n_fail++; $display("FAIL rstmid_next_frame got size=%0d first=%h expected 80 starting at 28", acc_log.size(),
                         (acc_log.size() != 0) ? acc_log[0] : 'x);
    end
  endtask

  task test_back_to_back();
    do_reset();
    for (int i = 0; i < 2 * FL; i++) push_val($urandom);
    frm_enable = 1;
    busy_low = 0;
    for (int i = 0; i < 800 && n_done < 2; i++) begin
      step();
      if (n_pops > 0 && n_pops < 2 * FL && frm_busy === 1'b0) busy_low++;
    end
    n_tests++;
    if (n_done !== 2 || n_pops !== 2 * FL) begin
      n_fail++; $display("FAIL b2b_counts got done=%0d pops=%0d expected 2/%0d", n_done, n_pops, 2 * FL);
    end
    n_tests++;
    if (pop_cyc.size() != 2 * FL || pop_cyc[FL] - pop_cyc[FL-1] != 3 ||
        pop_cyc[FL-1] - pop_cyc[0] != FL - 1 || pop_cyc[2*FL-1] - pop_cyc[FL] != FL - 1) begin
      n_fail++; $display("FAIL b2b_timing got pops=%0d expected two %0d-cycle bursts 3 cycles apart", pop_cyc.size(), FL);
    end
    n_tests++;
    if (busy_low != 1) begin n_fail++; $display("FAIL b2b_gap got %0d idle cycles expected 1", busy_low); end
    n_tests++;
    if (acc_log != exp_v) begin n_fail++; $display("FAIL b2b_data got %0d samples expected %0d in order", acc_log.size(), exp_v.size()); end
`ifdef ADS_FRM_RD_STATS_EN
    n_tests++;
    if (frm_count !== 16'd2) begin n_fail++; $display("FAIL b2b_frm_count got %0d expected 2", frm_count); end
`endif
  endtask

  task test_empty_stall();
    do_reset();
    for (int i = 0; i < FL; i++) push_val($urandom);
    frm_enable = 1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (frm_smp_valid === 1'b1 && frm_sample_idx === IW'(9)) found = 1;
    end
    force_empty = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (ldb_read_en !== 1'b0) begin n_fail++; $display("FAIL empty_no_pop k=%0d got %b expected 0", k, ldb_read_en); end
      step();
    end
    force_empty = 0;
    n_tests++;
    if (n_pops !== 10) begin n_fail++; $display("FAIL empty_pops got %0d expected 10", n_pops); end
    for (int i = 0; i < 300 && n_done < 1; i++) step();
    n_tests++;
    if (acc_log != exp_v || n_done !== 1) begin
      n_fail++; $display("FAIL empty_frame got %0d samples done=%0d expected %0d in order, 1 done", acc_log.size(), n_done, FL);
    end
`ifdef ADS_FRM_RD_STATS_EN
    n_tests++;
    if (frm_underrun !== 1'b1) begin n_fail++; $display("FAIL empty_underrun got %b expected 1", frm_underrun); end
`endif
  endtask

  task test_ce_enable();
    do_reset();
    for (int i = 0; i < FL; i++) push_val($urandom);
    frm_enable = 1;
    for (int i = 0; i < 3000 && acc_log.size() < FL; i++) begin
      sys_ce = ($urandom_range(3) != 0);
      frm_ready = $urandom_range(1);
      if (n_pops > 0) frm_enable = $urandom_range(1);
      step();
    end
    sys_ce = 1; frm_ready = 1; frm_enable = 0;
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (acc_log != exp_v) begin n_fail++; $display("FAIL ce_frame got %0d samples expected %0d in order", acc_log.size(), FL); end
    n_tests++;
    if (frm_busy !== 1'b0 || frm_smp_valid !== 1'b0) begin
      n_fail++; $display("FAIL ce_end_state got busy=%b valid=%b expected 0/0", frm_busy, frm_smp_valid);
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_single_frame();
    test_threshold();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_empty_stall();
    test_ce_enable();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
